wb_syscall_unit: RTL and testbench

Write-back-stage syscall and statistics unit for the 5-stage MIPS pipeline. It sits directly downstream of the MEM/WB pipeline buffer and consumes the retiring instruction's syscall flag, `$v0` and `$a0` values, and jump/branch flags. From these it produces:
- the pipeline-wide `halt` that gates PC and buffer enables;
- a latched display value plus a time-multiplexed 8-digit hex scan;
- cycle, jump and taken-branch counters for the board display.

---
 rtl/mips_pkg.sv | 13 +
 rtl/seg_scan.sv | 37 +++
 rtl/wb_syscall_unit.sv | 97 +++++++++
 tb/tb_wb_syscall_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: syscall codes and the
// write-back run/halt state encoding.
package mips_pkg;

  localparam logic [31:0] SYS_EXIT      = 32'd10;
  localparam logic [31:0] SYS_PRINT_HEX = 32'd34;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit hex scanner: a free-running divider steps the
// digit index, which selects the active-low anode and the displayed nibble.
module seg_scan #(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  output logic [7:0]  seg_an,
  output logic [3:0]  seg_digit
);

  logic [SCAN_DIV-1:0] div_q, div_d;
  logic [2:0]          idx_q, idx_d;

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (&div_q) begin
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= 3'd0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  assign seg_an    = ~(8'b0000_0001 << idx_q);
  assign seg_digit = value[{idx_q, 2'b00} +: 4];

endmodule

// File: rtl/wb_syscall_unit.sv
// Write-back syscall handling (halt/resume, print-hex latch), retirement
// statistics counters and the board hex display scan.
module wb_syscall_unit
  import mips_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic        wb_syscall,
  input  logic [31:0] wb_v0,
  input  logic [31:0] wb_a0,
  input  logic        wb_jmp,
  input  logic        wb_br_taken,
  input  logic        go,
  output logic        halt,
  output logic [31:0] disp_value,
  output logic [31:0] cycle_cnt,
  output logic [15:0] jmp_cnt,
  output logic [15:0] br_cnt,
  output logic [7:0]  seg_an,
  output logic [3:0]  seg_digit
);

  state_e      state_q, state_d;
  logic        mask_q, mask_d;
  logic [31:0] disp_q, disp_d;
  logic [31:0] cycle_q, cycle_d;
  logic [15:0] jmp_q, jmp_d;
  logic [15:0] br_q, br_d;
  logic        ev;

  // The instruction frozen in WB during HALT is still there on resume,
  // so the first cycle after resume must ignore it.
  assign ev = wb_valid & ~mask_q;

  always_comb begin
    state_d = state_q;
    mask_d  = 1'b0;
    disp_d  = disp_q;
    cycle_d = cycle_q;
    jmp_d   = jmp_q;
    br_d    = br_q;
    case (state_q)
      RUN: begin
        cycle_d = cycle_q + 32'd1;
        if (ev && wb_jmp)      jmp_d = jmp_q + 16'd1;
        if (ev && wb_br_taken) br_d  = br_q + 16'd1;
        if (ev && wb_syscall && wb_v0 == SYS_PRINT_HEX) disp_d = wb_a0;
        if (ev && wb_syscall && wb_v0 == SYS_EXIT)      state_d = HALT;
      end
      HALT: begin
        if (go) begin
          state_d = RUN;
          mask_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mask_q  <= 1'b0;
      disp_q  <= 32'd0;
      cycle_q <= 32'd0;
      jmp_q   <= 16'd0;
      br_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      disp_q  <= disp_d;
      cycle_q <= cycle_d;
      jmp_q   <= jmp_d;
      br_q    <= br_d;
    end
  end

  assign halt       = (state_q == HALT);
  assign disp_value = disp_q;
  assign cycle_cnt  = cycle_q;
  assign jmp_cnt    = jmp_q;
  assign br_cnt     = br_q;

  seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_seg_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (disp_q),
    .seg_an   (seg_an),
    .seg_digit(seg_digit)
  );

endmodule

// File: tb/tb_wb_syscall_unit.sv
// Directed self-checking bench for wb_syscall_unit with a short scan divider.
module tb_wb_syscall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_syscall, wb_jmp, wb_br_taken, go;
  logic [31:0] wb_v0, wb_a0;
  logic        halt;
  logic [31:0] disp_value, cycle_cnt;
  logic [15:0] jmp_cnt, br_cnt;
  logic [7:0]  seg_an;
  logic [3:0]  seg_digit;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;  // edges since the last reset release

  always #5 clk = ~clk;

  wb_syscall_unit #(.SCAN_DIV(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_syscall (wb_syscall),
    .wb_v0      (wb_v0),
    .wb_a0      (wb_a0),
    .wb_jmp     (wb_jmp),
    .wb_br_taken(wb_br_taken),
    .go         (go),
    .halt       (halt),
    .disp_value (disp_value),
    .cycle_cnt  (cycle_cnt),
    .jmp_cnt    (jmp_cnt),
    .br_cnt     (br_cnt),
    .seg_an     (seg_an),
    .seg_digit  (seg_digit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    wb_valid = 0; wb_syscall = 0; wb_jmp = 0; wb_br_taken = 0; go = 0;
    wb_v0 = 32'd0; wb_a0 = 32'd0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    cyc = 0;
    repeat (5) tick();
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%0b exp=0", halt); end
    total++; if (cycle_cnt !== 32'd5) begin bad++; $display("FAIL reset_cycle got=%0d exp=5", cycle_cnt); end
    total++; if (disp_value !== 32'd0) begin bad++; $display("FAIL reset_disp got=%h exp=0", disp_value); end
    // 5 edges with a 4-cycle digit period: idx=1
    total++; if (seg_an !== 8'hFD) begin bad++; $display("FAIL reset_an got=%h exp=fd", seg_an); end
    $display("reset: halt=%0b cycle=%0d an=%h", halt, cycle_cnt, seg_an);
  endtask

  task automatic test_print();
    logic [31:0] expv;
    logic [2:0]  ei;
    expv = 32'hDEADBEEF;
    wb_valid = 1; wb_syscall = 1; wb_v0 = 32'd34; wb_a0 = expv;
    tick();
    idle();
    total++; if (disp_value !== expv) begin bad++; $display("FAIL print_disp got=%h exp=%h", disp_value, expv); end
    for (int i = 0; i < 32; i++) begin
      ei = 3'((cyc / 4) % 8);
      total++;
      if (seg_an !== ~(8'd1 << ei) || seg_digit !== expv[ei*4 +: 4]) begin
        bad++;
        $display("FAIL scan cyc=%0d got an=%h dig=%h exp an=%h dig=%h",
                 cyc, seg_an, seg_digit, ~(8'd1 << ei), expv[ei*4 +: 4]);
      end
      tick();
    end
    $display("print: disp=%h", disp_value);
  endtask

  task automatic test_back_to_back();
    wb_valid = 1; wb_syscall = 1; wb_v0 = 32'd34; wb_a0 = 32'h1111_1111;
    tick();
    total++; if (disp_value !== 32'h1111_1111) begin bad++; $display("FAIL b2b_first got=%h exp=11111111", disp_value); end
    wb_a0 = 32'h2222_2222;
    tick();
    total++; if (disp_value !== 32'h2222_2222) begin bad++; $display("FAIL b2b_second got=%h exp=22222222", disp_value); end
    wb_v0 = 32'd5; wb_a0 = 32'h3333_3333;
    tick();
    total++; if (disp_value !== 32'h2222_2222 || halt !== 1'b0) begin bad++; $display("FAIL other_v0 got=%h halt=%0b exp=22222222 halt=0", disp_value, halt); end
    wb_valid = 0; wb_v0 = 32'd34;
    tick();
    total++; if (disp_value !== 32'h2222_2222) begin bad++; $display("FAIL invalid_print got=%h exp=22222222", disp_value); end
    idle();
    go = 1;
    tick();
    go = 0;
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL go_in_run got=%0b exp=0", halt); end
    $display("back_to_back: disp=%h", disp_value);
  endtask

  task automatic test_halt_resume();
    logic [31:0] c0;
    wb_valid = 1; wb_syscall = 1; wb_v0 = 32'd10;
    tick();
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_set got=%0b exp=1", halt); end
    c0 = cycle_cnt;
    wb_jmp = 1; wb_br_taken = 1;
    repeat (20) tick();
    total++; if (cycle_cnt !== c0 || jmp_cnt !== 16'd0 || br_cnt !== 16'd0) begin
      bad++; $display("FAIL halt_frozen got=%0d j=%0d b=%0d exp=%0d j=0 b=0", cycle_cnt, jmp_cnt, br_cnt, c0);
    end
    wb_jmp = 0; wb_br_taken = 0;
    go = 1;
    tick();
    go = 0;
    total++; if (halt !== 1'b0 || cycle_cnt !== c0) begin bad++; $display("FAIL resume got halt=%0b cyc=%0d exp halt=0 cyc=%0d", halt, cycle_cnt, c0); end
    wb_jmp = 1;
    tick();  // masked edge with syscall 10 and a jump still in WB
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL mask_rehalt got=%0b exp=0", halt); end
    total++; if (jmp_cnt !== 16'd0) begin bad++; $display("FAIL mask_jmp got=%0d exp=0", jmp_cnt); end
    total++; if (cycle_cnt !== c0 + 32'd1) begin bad++; $display("FAIL resume_cycle got=%0d exp=%0d", cycle_cnt, c0 + 32'd1); end
    idle();
    tick();
    $display("halt_resume: halt=%0b cycle=%0d", halt, cycle_cnt);
  endtask

  task automatic test_simultaneous();
    wb_valid = 1; wb_syscall = 1; wb_v0 = 32'd10; go = 1;
    tick();
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL sys10_with_go got=%0b exp=1", halt); end
    go = 1;
    tick();
    idle();
    tick();  // masked edge
    wb_valid = 1; wb_jmp = 1; wb_br_taken = 1;
    tick();
    total++; if (jmp_cnt !== 16'd1 || br_cnt !== 16'd1) begin bad++; $display("FAIL both_count got j=%0d b=%0d exp j=1 b=1", jmp_cnt, br_cnt); end
    wb_valid = 0;
    tick();
    total++; if (jmp_cnt !== 16'd1 || br_cnt !== 16'd1) begin bad++; $display("FAIL invalid_count got j=%0d b=%0d exp j=1 b=1", jmp_cnt, br_cnt); end
    idle();
    $display("simultaneous: j=%0d b=%0d", jmp_cnt, br_cnt);
  endtask

  task automatic test_wrap_reset();
    wb_valid = 1; wb_jmp = 1;
    repeat (65534) tick();
    total++; if (jmp_cnt !== 16'hFFFF) begin bad++; $display("FAIL jmp_max got=%h exp=ffff", jmp_cnt); end
    tick();
    total++; if (jmp_cnt !== 16'h0000 || br_cnt !== 16'd1) begin bad++; $display("FAIL jmp_wrap got j=%h b=%0d exp j=0 b=1", jmp_cnt, br_cnt); end
    idle();
    wb_valid = 1; wb_syscall = 1; wb_v0 = 32'd10;
    tick();
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL prereset_halt got=%0b exp=1", halt); end
    #2 rst_n = 0;
    #1;
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL async_halt got=%0b exp=0", halt); end
    total++; if (cycle_cnt !== 32'd0 || jmp_cnt !== 16'd0 || br_cnt !== 16'd0 || disp_value !== 32'd0) begin
      bad++; $display("FAIL async_regs got cyc=%0d j=%0d b=%0d d=%h exp all 0", cycle_cnt, jmp_cnt, br_cnt, disp_value);
    end
    total++; if (seg_an !== 8'hFE || seg_digit !== 4'h0) begin bad++; $display("FAIL async_scan got an=%h dig=%h exp an=fe dig=0", seg_an, seg_digit); end
    @(posedge clk);
    #1 rst_n = 1;
    idle();
    cyc = 0;
    tick();
    total++; if (halt !== 1'b0 || cycle_cnt !== 32'd1) begin bad++; $display("FAIL post_reset got halt=%0b cyc=%0d exp halt=0 cyc=1", halt, cycle_cnt); end
    $display("wrap_reset: j=%h halt=%0b", jmp_cnt, halt);
  endtask

  initial begin
    test_reset();
    test_print();
    test_back_to_back();
    test_halt_resume();
    test_simultaneous();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
